cc_branch_ctrl: RTL and testbench

//  Owns the architectural condition-code register (ZF/SF/OF) for the Y86-64 core.

---
 rtl/cc_branch_ctrl.sv | 156 +++++++++++++++
 tb/tb_cc_branch_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_branch_ctrl.sv
// cc_branch_ctrl
//   Holds the architectural condition codes (ZF/SF/OF) of the Y86-64 core.
//   It resolves jXX/cmovXX conditions in execute and, under always-taken
//   prediction, sequences mispredict recovery: a one-cycle PC redirect and a
//   timed squash of the younger instructions in fetch/decode. It also tracks
//   halt retirement and keeps saturating branch/mispredict statistics.
//
// Ports
//   clk, rst_n          core clock; asynchronous active-low reset
//   e_valid             execute holds a real instruction
//   e_icode, e_ifun     execute instruction code / function
//   alu_zf/sf/of        ALU flags produced this cycle
//   exc_pending         an older instruction has non-AOK status
//   e_valp              fall-through PC of the instruction in execute
//   e_cnd               combinational condition result for execute
//   zf_q, sf_q, of_q    registered condition codes
//   redirect_valid/pc   one-cycle fetch redirect with the corrected PC
//   squash              kill fetch/decode contents this cycle
//   halted              sticky halt indication
//   br_cnt, mp_cnt      saturating conditional-branch / mispredict counts
//
// State table
//   state     | meaning
//   ST_RUN    | normal execution; execute stage may act
//   ST_SQUASH | mispredict recovery; squash held, execute ignored
//   ST_HALT   | halt retired; absorbing until reset
module cc_branch_ctrl #(
  parameter int unsigned SQUASH_CYC = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned PC_W       = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            e_valid,
  input  logic [3:0]      e_icode,
  input  logic [3:0]      e_ifun,
  input  logic            alu_zf,
  input  logic            alu_sf,
  input  logic            alu_of,
  input  logic            exc_pending,
  input  logic [PC_W-1:0] e_valp,
  output logic            e_cnd,
  output logic            zf_q,
  output logic            sf_q,
  output logic            of_q,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            squash,
  output logic            halted,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mp_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_SQUASH = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  // The squash timer is loaded with SQUASH_CYC-1 so that terminal count (0)
  // lands on the last squash cycle.
  localparam logic [3:0]       SQ_LOAD = 4'(SQUASH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t     state, state_nx;
  logic [3:0] sq_tmr;
  logic       act;
  logic       is_halt, is_cmov, is_opq, is_jxx;
  logic       cond;
  logic       mispredict;
  logic       take_halt;
  logic       lt;

  assign lt = sf_q ^ of_q;

  // Condition evaluated from the registered flags only.
  always_comb begin
    cond = 1'b0;
    case (e_ifun)
      4'd0:    cond = 1'b1;
      4'd1:    cond = zf_q | lt;
      4'd2:    cond = lt;
      4'd3:    cond = zf_q;
      4'd4:    cond = ~zf_q;
      4'd5:    cond = ~lt;
      4'd6:    cond = ~zf_q & ~lt;
      default: cond = 1'b0;
    endcase
  end

  assign act        = (state == ST_RUN) && e_valid && !exc_pending;
  assign is_halt    = (e_icode == 4'd0);
  assign is_cmov    = (e_icode == 4'd2);
  assign is_opq     = (e_icode == 4'd6);
  assign is_jxx     = (e_icode == 4'd7);
  assign e_cnd      = act && (is_jxx || is_cmov) && cond;
  // jmp (ifun 0) has cond=1 and so can never mispredict.
  assign mispredict = act && is_jxx && !cond;
  assign take_halt  = act && is_halt;

  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN: begin
        if (take_halt)       state_nx = ST_HALT;
        else if (mispredict) state_nx = ST_SQUASH;
      end
      ST_SQUASH: begin
        if (sq_tmr == 4'd0)  state_nx = ST_RUN;
      end
      ST_HALT:   state_nx = ST_HALT;
      default:   state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nx;
  end

  assign squash = (state == ST_SQUASH);
  assign halted = (state == ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_tmr         <= 4'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      zf_q           <= 1'b1;
      sf_q           <= 1'b0;
      of_q           <= 1'b0;
      br_cnt         <= '0;
      mp_cnt         <= '0;
    end else begin
      redirect_valid <= mispredict;
      if (mispredict) begin
        redirect_pc <= e_valp;
        sq_tmr      <= SQ_LOAD;
      end else if (state == ST_SQUASH && sq_tmr != 4'd0) begin
        sq_tmr <= sq_tmr - 4'd1;
      end

      if (act && is_opq) begin
        zf_q <= alu_zf;
        sf_q <= alu_sf;
        of_q <= alu_of;
      end

      if (act && is_jxx && e_ifun != 4'd0 && br_cnt != '1)
        br_cnt <= br_cnt + CNT_ONE;
      if (mispredict && mp_cnt != '1)
        mp_cnt <= mp_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_cc_branch_ctrl.sv
// Bench for cc_branch_ctrl: two instances (default parameters, and
// SQUASH_CYC=3 / CNT_W=2) share stimulus and are each tracked by a
// behavioural model; a directed table and hand sequences cover corner cases.
module tb_cc_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        e_valid = 1'b0;
  logic [3:0]  e_icode = 4'd1;
  logic [3:0]  e_ifun = 4'd0;
  logic        alu_zf = 1'b0, alu_sf = 1'b0, alu_of = 1'b0;
  logic        exc_pending = 1'b0;
  logic [63:0] e_valp = 64'd0;

  logic        cnd0, zf0, sf0, of0, rv0, sq0, h0;
  logic [63:0] rpc0;
  logic [15:0] br0, mp0;
  logic        cnd1, zf1, sf1, of1, rv1, sq1, h1;
  logic [63:0] rpc1;
  logic [1:0]  br1, mp1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cc_branch_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of), .exc_pending(exc_pending),
    .e_valp(e_valp), .e_cnd(cnd0), .zf_q(zf0), .sf_q(sf0), .of_q(of0),
    .redirect_valid(rv0), .redirect_pc(rpc0), .squash(sq0), .halted(h0),
    .br_cnt(br0), .mp_cnt(mp0)
  );

  cc_branch_ctrl #(.SQUASH_CYC(3), .CNT_W(2), .PC_W(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of), .exc_pending(exc_pending),
    .e_valp(e_valp), .e_cnd(cnd1), .zf_q(zf1), .sf_q(sf1), .of_q(of1),
    .redirect_valid(rv1), .redirect_pc(rpc1), .squash(sq1), .halted(h1),
    .br_cnt(br1), .mp_cnt(mp1)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit          zf, sf, of;
    int          sq_left;   // squash cycles still to come
    bit          halted;
    bit          rv;
    logic [63:0] rpc;
    int          br, mp;
  } mdl_t;

  mdl_t m[2];
  int   sqc[2]  = '{2, 3};
  int   cmax[2] = '{65535, 3};

  function automatic mdl_t m_reset();
    mdl_t r;
    r.zf = 1; r.sf = 0; r.of = 0; r.sq_left = 0; r.halted = 0;
    r.rv = 0; r.rpc = 64'd0; r.br = 0; r.mp = 0;
    return r;
  endfunction

  function automatic bit m_cond(mdl_t s, int ifn);
    bit lt = (s.sf != s.of);
    case (ifn)
      0: return 1;
      1: return s.zf || lt;
      2: return lt;
      3: return s.zf;
      4: return !s.zf;
      5: return !lt;
      6: return !s.zf && !lt;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_act(mdl_t s, bit v, bit ex);
    return !s.halted && s.sq_left == 0 && v && !ex;
  endfunction

  function automatic bit m_cnd(mdl_t s, bit v, int ic, int ifn, bit ex);
    if (m_act(s, v, ex) && (ic == 2 || ic == 7)) return m_cond(s, ifn);
    return 0;
  endfunction

  function automatic mdl_t m_step(mdl_t s, bit v, int ic, int ifn, logic [2:0] al,
                                  bit ex, logic [63:0] vp, int sc, int cm);
    mdl_t n = s;
    bit a = m_act(s, v, ex);
    n.rv = 0;
    if (s.sq_left > 0) n.sq_left = s.sq_left - 1;
    if (a && ic == 6) begin
      n.zf = al[2]; n.sf = al[1]; n.of = al[0];
    end
    if (a && ic == 0) n.halted = 1;
    if (a && ic == 7 && ifn != 0 && s.br < cm) n.br = s.br + 1;
    if (a && ic == 7 && !m_cond(s, ifn)) begin
      n.rv = 1; n.rpc = vp; n.sq_left = sc;
      if (s.mp < cm) n.mp = s.mp + 1;
    end
    return n;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_regs(input int i);
    string p = $sformatf("dut%0d ", i);
    chk({p, "flags"}, (i == 0) ? {61'd0, zf0, sf0, of0} : {61'd0, zf1, sf1, of1},
        {61'd0, m[i].zf, m[i].sf, m[i].of});
    chk({p, "redirect_valid"}, (i == 0) ? 64'(rv0) : 64'(rv1), 64'(m[i].rv));
    if (m[i].rv) chk({p, "redirect_pc"}, (i == 0) ? rpc0 : rpc1, m[i].rpc);
    chk({p, "squash"}, (i == 0) ? 64'(sq0) : 64'(sq1), 64'(m[i].sq_left > 0));
    chk({p, "halted"}, (i == 0) ? 64'(h0) : 64'(h1), 64'(m[i].halted));
    chk({p, "br_cnt"}, (i == 0) ? 64'(br0) : 64'(br1), 64'(m[i].br));
    chk({p, "mp_cnt"}, (i == 0) ? 64'(mp0) : 64'(mp1), 64'(m[i].mp));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit v; logic [3:0] ic, ifn; logic [2:0] al; bit ex; logic [63:0] vp;
    bit cnd; logic [2:0] flg; bit rv; logic [63:0] rpc; bit sq, hlt; int br, mp;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(bit v, int ic, int ifn, logic [2:0] al, bit ex,
                              logic [63:0] vp, bit cnd, logic [2:0] flg, bit rv,
                              logic [63:0] rpc, bit sq, bit hlt, int br, int mp);
    vec_t t;
    t.v = v; t.ic = 4'(ic); t.ifn = 4'(ifn); t.al = al; t.ex = ex; t.vp = vp;
    t.cnd = cnd; t.flg = flg; t.rv = rv; t.rpc = rpc; t.sq = sq; t.hlt = hlt;
    t.br = br; t.mp = mp;
    return t;
  endfunction

  // One clock: drive, check e_cnd before the edge, step models, check after.
  task automatic cycle(input bit v, input int ic, input int ifn, input logic [2:0] al,
                       input bit ex, input logic [63:0] vp, input int tr);
    e_valid = v; e_icode = 4'(ic); e_ifun = 4'(ifn);
    alu_zf = al[2]; alu_sf = al[1]; alu_of = al[0];
    exc_pending = ex; e_valp = vp;
    #2;
    chk("dut0 e_cnd", 64'(cnd0), 64'(m_cnd(m[0], v, ic, ifn, ex)));
    chk("dut1 e_cnd", 64'(cnd1), 64'(m_cnd(m[1], v, ic, ifn, ex)));
    if (tr >= 0) chk($sformatf("tbl%0d e_cnd", tr), 64'(cnd0), 64'(tbl[tr].cnd));
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      m[i] = m_step(m[i], v, ic, ifn, al, ex, vp, sqc[i], cmax[i]);
      check_regs(i);
    end
    if (tr >= 0) begin
      chk($sformatf("tbl%0d flags", tr), {61'd0, zf0, sf0, of0}, {61'd0, tbl[tr].flg});
      chk($sformatf("tbl%0d redirect_valid", tr), 64'(rv0), 64'(tbl[tr].rv));
      if (tbl[tr].rv) chk($sformatf("tbl%0d redirect_pc", tr), rpc0, tbl[tr].rpc);
      chk($sformatf("tbl%0d squash", tr), 64'(sq0), 64'(tbl[tr].sq));
      chk($sformatf("tbl%0d halted", tr), 64'(h0), 64'(tbl[tr].hlt));
      chk($sformatf("tbl%0d br_cnt", tr), 64'(br0), 64'(tbl[tr].br));
      chk($sformatf("tbl%0d mp_cnt", tr), 64'(mp0), 64'(tbl[tr].mp));
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      m[i] = m_reset();
      check_regs(i);
    end
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = mk(1, 6, 0, 3'b010, 0, 64'h0,  0, 3'b010, 0, 64'h0,  0, 0, 0, 0);
    tbl[1]  = mk(1, 7, 2, 3'b000, 0, 64'h10, 1, 3'b010, 0, 64'h0,  0, 0, 1, 0);
    tbl[2]  = mk(1, 6, 0, 3'b000, 0, 64'h0,  0, 3'b000, 0, 64'h0,  0, 0, 1, 0);
    tbl[3]  = mk(1, 7, 3, 3'b000, 0, 64'h40, 0, 3'b000, 1, 64'h40, 1, 0, 2, 1);
    tbl[4]  = mk(1, 6, 0, 3'b111, 0, 64'h0,  0, 3'b000, 0, 64'h0,  1, 0, 2, 1);
    tbl[5]  = mk(1, 6, 0, 3'b111, 0, 64'h0,  0, 3'b000, 0, 64'h0,  0, 0, 2, 1);
    tbl[6]  = mk(1, 6, 0, 3'b111, 1, 64'h0,  0, 3'b000, 0, 64'h0,  0, 0, 2, 1);
    tbl[7]  = mk(1, 7, 4, 3'b000, 1, 64'h50, 0, 3'b000, 0, 64'h0,  0, 0, 2, 1);
    tbl[8]  = mk(1, 7, 4, 3'b000, 0, 64'h80, 1, 3'b000, 0, 64'h0,  0, 0, 3, 1);
    tbl[9]  = mk(1, 2, 0, 3'b000, 0, 64'h0,  1, 3'b000, 0, 64'h0,  0, 0, 3, 1);
    tbl[10] = mk(1, 2, 8, 3'b000, 0, 64'h0,  0, 3'b000, 0, 64'h0,  0, 0, 3, 1);
    tbl[11] = mk(1, 7, 0, 3'b000, 0, 64'h90, 1, 3'b000, 0, 64'h0,  0, 0, 3, 1);
    tbl[12] = mk(0, 6, 0, 3'b111, 0, 64'h0,  0, 3'b000, 0, 64'h0,  0, 0, 3, 1);
    tbl[13] = mk(1, 0, 0, 3'b000, 0, 64'h0,  0, 3'b000, 0, 64'h0,  0, 1, 3, 1);
    tbl[14] = mk(1, 6, 0, 3'b111, 0, 64'h0,  0, 3'b000, 0, 64'h0,  0, 1, 3, 1);
    tbl[15] = mk(1, 7, 4, 3'b000, 0, 64'h60, 0, 3'b000, 0, 64'h0,  0, 1, 3, 1);

    @(posedge clk);
    #1;
    do_reset();

    for (int r = 0; r < 16; r++)
      cycle(tbl[r].v, int'(tbl[r].ic), int'(tbl[r].ifn), tbl[r].al, tbl[r].ex, tbl[r].vp, r);

    // Reset while halted.
    do_reset();
    chk("reset halted", 64'(h0), 64'd0);
    chk("reset zf", 64'(zf0), 64'd1);

    // Counter saturation: 5 taken je (ZF=1 after reset), then 4 mispredicting jne.
    for (int k = 0; k < 5; k++) cycle(1, 7, 3, 3'b000, 0, 64'h100, -1);
    chk("sat br_cnt dut1", 64'(br1), 64'd3);
    chk("br_cnt dut0 after 5", 64'(br0), 64'd5);
    for (int k = 0; k < 4; k++) begin
      cycle(1, 7, 4, 3'b000, 0, 64'h200 + 64'(k), -1);
      for (int j = 0; j < 3; j++) cycle(0, 1, 0, 3'b000, 0, 64'h0, -1);
    end
    chk("sat mp_cnt dut1", 64'(mp1), 64'd3);
    chk("mp_cnt dut0 after 4", 64'(mp0), 64'd4);

    // Reset in the middle of a squash.
    cycle(1, 7, 4, 3'b000, 0, 64'h300, -1);
    chk("mid-squash squash", 64'(sq0), 64'd1);
    do_reset();
    chk("reset squash", 64'(sq0), 64'd0);

    // Randomized run against the models.
    for (int c = 0; c < 3000; c++) begin
      int r, ic, ifn;
      bit v, ex;
      if (c % 250 == 249) do_reset();
      r = $urandom_range(0, 99);
      if (r < 2)       ic = 0;
      else if (r < 30) ic = 6;
      else if (r < 60) ic = 7;
      else if (r < 75) ic = 2;
      else             ic = $urandom_range(0, 15);
      ifn = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 6) : $urandom_range(0, 15);
      v  = ($urandom_range(0, 9) != 0);
      ex = ($urandom_range(0, 9) == 0);
      cycle(v, ic, ifn, 3'($urandom_range(0, 7)), ex, {$urandom, $urandom}, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
